// File: rtl/mips_pkg.sv
// Shared widths, control/branch bit positions and branch-resolution helper
// for the EX/MEM boundary of the MIPS pipeline.
package mips_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  // in_ctrl = {regwrite, memread, memwrite, memtoreg}
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;
  localparam int CTRL_W        = 4;

  // in_br = {beq, bgtz}
  localparam int BR_BEQ  = 1;
  localparam int BR_BGTZ = 0;
  localparam int BR_W    = 2;

  // An overflowing instruction is nullified, so it can never redirect fetch.
  function automatic logic br_resolve(input logic [BR_W-1:0] br, input logic zero,
                                      input logic bgt, input logic oflow);
    return ((br[BR_BEQ] & zero) | (br[BR_BGTZ] & bgt)) & ~oflow;
  endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// Two-entry in-order buffer with valid/ready on both sides; the head entry
// (oldest) is always presented on out_data.
module ex_mem_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         push;
  logic         pop;

  // Gated by the reset pin so ready is low during reset and high on the very
  // first edge after release, without any combinational path from out_ready.
  assign in_ready  = rst_n & (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // NOTE: storage entries are reset too, so out_data is never X while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else if (push && !pop) begin
      if (count_q == 2'd0) head_q <= in_data;
      else                 tail_q <= in_data;
      count_q <= count_q + 2'd1;
    end else if (pop && !push) begin
      head_q  <= tail_q;
      count_q <= count_q - 2'd1;
    end else if (push && pop) begin
      if (count_q == 2'd1) begin
        head_q <= in_data;
      end else begin
        head_q <= tail_q;
        tail_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: buffers EX results for MEM, resolves branches and
// raises the overflow exception one cycle after the instruction is accepted.
module ex_mem_stage #(
  parameter int DW = mips_pkg::DW,
  parameter int RW = mips_pkg::RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pc,
  input  logic [DW-1:0] in_alu_out,
  input  logic          in_zero,
  input  logic          in_oflow,
  input  logic          in_bgt,
  input  logic [DW-1:0] in_rt_data,
  input  logic [RW-1:0] in_dest,
  input  logic [3:0]    in_ctrl,
  input  logic [1:0]    in_br,
  input  logic [DW-1:0] in_br_target,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_alu,
  output logic [DW-1:0] out_rt_data,
  output logic [RW-1:0] out_dest,
  output logic [3:0]    out_ctrl,
  output logic          br_taken,
  output logic [DW-1:0] br_target,
  output logic          exc,
  output logic [DW-1:0] epc
);

  import mips_pkg::*;

  localparam int EW = 2*DW + RW + CTRL_W;

  logic          accept;
  logic [3:0]    ctrl_eff;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] entry_out;
  logic          br_taken_q;
  logic          exc_q;
  logic [DW-1:0] br_target_q;
  logic [DW-1:0] epc_q;

  assign accept   = in_valid & in_ready & ~flush;
  assign ctrl_eff = in_oflow ? 4'b0000 : in_ctrl;
  assign entry_in = {in_alu_out, in_rt_data, in_dest, ctrl_eff};

  ex_mem_skid #(.W(EW)) u_skid (
    .clk       (clk),
    .rst_n     (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (entry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (entry_out)
  );

  assign {out_alu, out_rt_data, out_dest, out_ctrl} = entry_out;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_taken_q  <= 1'b0;
      exc_q       <= 1'b0;
      br_target_q <= '0;
      epc_q       <= '0;
    end else begin
      br_taken_q <= accept & br_resolve(in_br, in_zero, in_bgt, in_oflow);
      exc_q      <= accept & in_oflow;
      if (accept && br_resolve(in_br, in_zero, in_bgt, in_oflow)) br_target_q <= in_br_target;
      if (accept && in_oflow) epc_q <= in_pc;
    end
  end

  assign br_taken  = br_taken_q;
  assign exc       = exc_q;
  assign br_target = br_target_q;
  assign epc       = epc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: streaming, back-pressure, overflow,
// branch resolution, flush and mid-stream reset.
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pc;
  logic [DW-1:0] in_alu_out;
  logic          in_zero;
  logic          in_oflow;
  logic          in_bgt;
  logic [DW-1:0] in_rt_data;
  logic [RW-1:0] in_dest;
  logic [3:0]    in_ctrl;
  logic [1:0]    in_br;
  logic [DW-1:0] in_br_target;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_alu;
  logic [DW-1:0] out_rt_data;
  logic [RW-1:0] out_dest;
  logic [3:0]    out_ctrl;
  logic          br_taken;
  logic [DW-1:0] br_target;
  logic          exc;
  logic [DW-1:0] epc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_alu_out   (in_alu_out),
    .in_zero      (in_zero),
    .in_oflow     (in_oflow),
    .in_bgt       (in_bgt),
    .in_rt_data   (in_rt_data),
    .in_dest      (in_dest),
    .in_ctrl      (in_ctrl),
    .in_br        (in_br),
    .in_br_target (in_br_target),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu      (out_alu),
    .out_rt_data  (out_rt_data),
    .out_dest     (out_dest),
    .out_ctrl     (out_ctrl),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .exc          (exc),
    .epc          (epc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, well away from the edge itself.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_pc = '0; in_alu_out = '0; in_zero = 0; in_oflow = 0;
    in_bgt = 0; in_rt_data = '0; in_dest = '0; in_ctrl = '0; in_br = '0;
    in_br_target = '0; flush = 0;
  endtask

  task automatic drive(input logic [DW-1:0] alu, input logic [DW-1:0] pc);
    in_valid = 1; in_alu_out = alu; in_pc = pc;
    in_rt_data = alu + 32'h1; in_dest = alu[RW-1:0]; in_ctrl = 4'b1010;
  endtask

  initial begin
    idle_inputs();
    out_ready = 0;
    rst = 0;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_br_taken", br_taken, 0);
    check("rst_exc", exc, 0);
    check("rst_epc", epc, 0);
    check("rst_br_target", br_target, 0);
    check("rst_out_data", {out_alu, out_ctrl}, 0);
    rst = 1;
    #1;
    check("rel_in_ready", in_ready, 1);
    step();

    // Streaming with MEM always ready.
    out_ready = 1;
    drive(32'h10, 32'h100); step();
    check("s0_valid", out_valid, 1); check("s0_alu", out_alu, 32'h10);
    check("s0_rt", out_rt_data, 32'h11); check("s0_ready", in_ready, 1);
    drive(32'h20, 32'h104); step();
    check("s1_alu", out_alu, 32'h20); check("s1_ready", in_ready, 1);
    drive(32'h30, 32'h108); step();
    check("s2_alu", out_alu, 32'h30); check("s2_ctrl", out_ctrl, 4'b1010);
    idle_inputs(); step();
    check("s3_empty", out_valid, 0);

    // Back-pressure: two accepted, third held until MEM drains.
    out_ready = 0;
    drive(32'h10, 32'h200); step();
    check("bp0_ready", in_ready, 1);
    drive(32'h20, 32'h204); step();
    check("bp1_ready", in_ready, 0); check("bp1_head", out_alu, 32'h10);
    drive(32'h30, 32'h208); step();
    check("bp2_ready", in_ready, 0); check("bp2_head", out_alu, 32'h10);
    out_ready = 1; step();
    check("bp3_head", out_alu, 32'h20); check("bp3_ready", in_ready, 1);
    step();
    check("bp4_head", out_alu, 32'h30); check("bp4_valid", out_valid, 1);
    idle_inputs(); step();
    check("bp5_empty", out_valid, 0);

    // Overflow nullifies the entry and raises a one-cycle exception.
    out_ready = 0;
    drive(32'h44, 32'h400); in_oflow = 1; in_ctrl = 4'b1000; step();
    check("ov_valid", out_valid, 1); check("ov_ctrl", out_ctrl, 0);
    check("ov_exc", exc, 1); check("ov_epc", epc, 32'h400);
    idle_inputs(); out_ready = 1; step();
    check("ov_exc_end", exc, 0); check("ov_epc_keep", epc, 32'h400);
    check("ov_drained", out_valid, 0);

    // Branch resolution.
    drive(32'h0, 32'h300); in_br = 2'b10; in_zero = 1; in_br_target = 32'h80; step();
    check("beq_taken", br_taken, 1); check("beq_target", br_target, 32'h80);
    idle_inputs(); step();
    check("beq_pulse_end", br_taken, 0);
    drive(32'h5, 32'h304); in_br = 2'b10; in_zero = 0; in_br_target = 32'h90; step();
    check("beq_nt", br_taken, 0); check("beq_nt_target", br_target, 32'h80);
    idle_inputs();
    drive(32'h6, 32'h500); in_br = 2'b01; in_bgt = 1; in_oflow = 1; in_br_target = 32'hA0; step();
    check("bgtz_ov_nt", br_taken, 0); check("bgtz_ov_exc", exc, 1);
    check("bgtz_ov_epc", epc, 32'h500);
    idle_inputs(); step();

    // Flush with a full buffer and a taken branch on the input.
    out_ready = 0;
    drive(32'hA1, 32'h600); step();
    drive(32'hA2, 32'h604); step();
    check("fl_full", in_ready, 0);
    drive(32'hA3, 32'h700); in_br = 2'b01; in_bgt = 1; in_oflow = 1; flush = 1; step();
    check("fl_valid", out_valid, 0); check("fl_br", br_taken, 0);
    check("fl_exc", exc, 0); check("fl_epc", epc, 32'h500);
    check("fl_ready", in_ready, 1);
    idle_inputs(); step();
    check("fl_still_empty", out_valid, 0);

    // Reset in the middle of a cycle with one entry buffered.
    drive(32'hB1, 32'h800); in_br = 2'b10; in_zero = 1; in_br_target = 32'hC0; step();
    check("mr_pre_valid", out_valid, 1); check("mr_pre_br", br_taken, 1);
    idle_inputs();
    #1; rst = 0; #1;
    check("mr_valid", out_valid, 0); check("mr_ready", in_ready, 0);
    check("mr_br", br_taken, 0); check("mr_target", br_target, 0);
    check("mr_epc", epc, 0); check("mr_alu", out_alu, 0);
    #1; rst = 1; step();
    check("mr_rel_ready", in_ready, 1); check("mr_rel_br", br_taken, 0);
    check("mr_rel_exc", exc, 0); check("mr_rel_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
